// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment decoder: segment bit positions,
// the hex glyph table and the output polarity helper.
package sseg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Glyphs in {g,f,e,d,c,b,a} order; b and d are lower case to stay distinct from 8 and 0.
   localparam logic [6:0] HEX_SEG [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [7:0] SEG_DARK = 8'h00;

   function automatic logic [7:0] apply_polarity(input logic [7:0] value, input logic invert);
      logic [7:0] result;
      if (invert) begin
         result = ~value;
      end else begin
         result = value;
      end
      return result;
   endfunction

endpackage

// File: rtl/sseg_hex_lut.sv
// Combinational hex-digit to segment lookup, {g,f,e,d,c,b,a}.
module sseg_hex_lut
   import sseg_pkg::*;
(
   input  logic [3:0] num,
   output logic [6:0] seg
);

   // All 16 codes have a glyph, so the lookup never yields X.
   always_comb begin
      seg = HEX_SEG[num];
   end

endmodule

// File: rtl/sseg_decoder.sv
// Single-digit seven-segment decoder with decimal point, blanking,
// selectable output polarity and optional output register.
module sseg_decoder
   import sseg_pkg::*;
#(
   parameter int ACTIVE_LOW = 0,
   parameter int OUT_REG    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] num,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] cathode
);

   localparam logic       INVERT   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [7:0] DARK_OUT = apply_polarity(SEG_DARK, INVERT);

   logic [6:0] seg_s;
   logic [7:0] active_s;
   logic [7:0] cathode_d;

   sseg_hex_lut u_lut (
      .num (num),
      .seg (seg_s)
   );

   // Active-high pattern first, then polarity; blank overrides both glyph and dp.
   always_comb begin
      active_s         = {1'b0, seg_s};
      active_s[SEG_DP] = dp;
      if (blank) begin
         cathode_d = apply_polarity(SEG_DARK, INVERT);
      end else begin
         cathode_d = apply_polarity(active_s, INVERT);
      end
   end

   if (OUT_REG != 0) begin : g_reg
      logic [7:0] cathode_q;

      // Output register; reset loads the dark pattern for the chosen polarity.
      always_ff @(posedge clk) begin
         if (reset) begin
            cathode_q <= DARK_OUT;
         end else begin
            cathode_q <= cathode_d;
         end
      end

      assign cathode = cathode_q;
   end else begin : g_comb
      assign cathode = cathode_d;
   end

endmodule

// File: tb/tb_sseg_decoder.sv
// Directed bench for sseg_decoder: active-high registered, active-low
// registered and combinational instances driven from shared inputs.
module tb_sseg_decoder;

   logic       clk;
   logic       reset;
   logic [3:0] num;
   logic       dp;
   logic       blank;
   logic [7:0] cath_hi;
   logic [7:0] cath_lo;
   logic [7:0] cath_cb;

   int total;
   int bad;

   localparam logic [7:0] EXP [0:15] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   sseg_decoder #(.ACTIVE_LOW(0), .OUT_REG(1)) u_hi (
      .clk(clk), .reset(reset), .num(num), .dp(dp), .blank(blank), .cathode(cath_hi)
   );

   sseg_decoder #(.ACTIVE_LOW(1), .OUT_REG(1)) u_lo (
      .clk(clk), .reset(reset), .num(num), .dp(dp), .blank(blank), .cathode(cath_lo)
   );

   sseg_decoder #(.ACTIVE_LOW(0), .OUT_REG(0)) u_cb (
      .clk(clk), .reset(reset), .num(num), .dp(dp), .blank(blank), .cathode(cath_cb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] prev;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      num   = 4'h9;
      dp    = 1'b0;
      blank = 1'b0;

      // 1. reset, then first decode
      step();
      step();
      check("rst_hi", cath_hi, 8'h00);
      check("rst_lo", cath_lo, 8'hFF);
      check("rst_comb_ignored", cath_cb, 8'h6F);
      reset = 1'b0;
      #1;
      check("rst_release_hold_hi", cath_hi, 8'h00);
      step();
      check("first_hi", cath_hi, 8'h6F);
      check("first_lo", cath_lo, 8'h90);

      // 2. sweep 0..F with latency check before each edge
      prev = 8'h6F;
      for (int i = 0; i < 16; i++) begin
         num = i[3:0];
         #1;
         check($sformatf("comb_%0h", i), cath_cb, EXP[i]);
         check($sformatf("latency_%0h", i), cath_hi, prev);
         step();
         check($sformatf("sweep_hi_%0h", i), cath_hi, EXP[i]);
         check($sformatf("sweep_lo_%0h", i), cath_lo, ~EXP[i]);
         prev = EXP[i];
      end

      // 3. decimal point and blank
      num = 4'h8;
      dp  = 1'b1;
      step();
      check("dp8_hi", cath_hi, 8'hFF);
      check("dp8_lo", cath_lo, 8'h00);
      blank = 1'b1;
      step();
      check("blank_hi", cath_hi, 8'h00);
      check("blank_lo", cath_lo, 8'hFF);
      check("blank_comb", cath_cb, 8'h00);

      // 4/5. reset mid-sweep has priority and resumes afterwards
      blank = 1'b0;
      dp    = 1'b0;
      num   = 4'h3;
      step();
      check("resume_3", cath_hi, 8'h4F);
      num = 4'h5;
      step();
      check("pre_rst_5", cath_hi, 8'h6D);
      reset = 1'b1;
      dp    = 1'b1;
      step();
      check("mid_rst_hi", cath_hi, 8'h00);
      check("mid_rst_lo", cath_lo, 8'hFF);
      check("mid_rst_comb", cath_cb, 8'hED);
      reset = 1'b0;
      dp    = 1'b0;
      step();
      check("post_rst_hi", cath_hi, 8'h6D);
      check("post_rst_lo", cath_lo, 8'h92);

      // 6. combinational instance without an intervening clock edge
      @(negedge clk);
      num = 4'h9;
      #1;
      check("comb_9", cath_cb, 8'h6F);
      num = 4'h4;
      dp  = 1'b1;
      #1;
      check("comb_4dp", cath_cb, 8'hE6);
      check("reg_holds", cath_hi, 8'h6D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
